cmac_tx_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one CMAC TX datapath (512-bit AXI-Stream feeding the AXI-to-LBUS TX converter) among C_NUM_PORTS AXI-Stream sources.
- A grant is held from the first beat of a packet until its TLAST beat is accepted, so packets are never interleaved.
- Output is registered. Back-to-back packets from different ports pass with no idle cycle.

---
 rtl/cmac_tx_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cmac_tx_rr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_tx_rr_arbiter.sv
// Packet-granular round-robin arbiter: N AXI-Stream sources share one CMAC TX stream.
// Latency: 1 cycle from slave acceptance to M_AXIS_TVALID (single output register).
// Backpressure: slave TREADY only to the granted port while the output register can advance.
module cmac_tx_rr_arbiter #(
  parameter int C_NUM_PORTS  = 4,
  parameter int C_DATA_WIDTH = 512,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [C_NUM_PORTS-1:0]                  S_AXIS_TVALID,
  output logic [C_NUM_PORTS-1:0]                  S_AXIS_TREADY,
  input  logic [C_NUM_PORTS-1:0]                  S_AXIS_TLAST,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  output logic                                    M_AXIS_TVALID,
  input  logic                                    M_AXIS_TREADY,
  output logic                                    M_AXIS_TLAST,
  output logic [C_DATA_WIDTH-1:0]                 M_AXIS_TDATA,
  output logic [C_DATA_WIDTH/8-1:0]               M_AXIS_TSTRB,
  output logic [C_NUM_PORTS-1:0]                  GRANT_ONEHOT,
  output logic [C_NUM_PORTS*C_CNT_WIDTH-1:0]      PKT_CNT
);

  localparam int C_STRB_WIDTH = C_DATA_WIDTH / 8;
  localparam int C_IDX_WIDTH  = $clog2(C_NUM_PORTS);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                   r_state, w_state_nxt;
  logic [C_IDX_WIDTH-1:0]   r_owner, w_owner_nxt;
  logic [C_IDX_WIDTH-1:0]   r_last_grant, w_last_grant_nxt;

  logic                     r_m_tvalid;
  logic                     r_m_tlast;
  logic [C_DATA_WIDTH-1:0]  r_m_tdata;
  logic [C_STRB_WIDTH-1:0]  r_m_tstrb;
  logic [C_NUM_PORTS-1:0]   r_grant;
  logic [C_CNT_WIDTH-1:0]   r_pkt_cnt [C_NUM_PORTS];

  logic                     w_adv;
  logic                     w_srch_vld;
  logic [C_IDX_WIDTH-1:0]   w_srch_idx;
  logic                     w_gnt_vld;
  logic [C_IDX_WIDTH-1:0]   w_gnt_idx;
  logic [C_NUM_PORTS-1:0]   w_gnt_oh;
  logic                     w_acc;
  logic                     w_acc_last;
  logic [C_DATA_WIDTH-1:0]  w_dat_arr  [C_NUM_PORTS];
  logic [C_STRB_WIDTH-1:0]  w_strb_arr [C_NUM_PORTS];

  // Output register may take a new beat when empty or being drained this cycle.
  assign w_adv = ~r_m_tvalid | M_AXIS_TREADY;

  // Round-robin search: first valid port after the previous winner.
  always_comb begin
    int v_p;
    v_p        = 0;
    w_srch_vld = 1'b0;
    w_srch_idx = '0;
    for (int k = 1; k <= C_NUM_PORTS; k++) begin
      v_p = (int'(r_last_grant) + k) % C_NUM_PORTS;
      if (!w_srch_vld && S_AXIS_TVALID[C_IDX_WIDTH'(v_p)]) begin
        w_srch_vld = 1'b1;
        w_srch_idx = C_IDX_WIDTH'(v_p);
      end
    end
  end

  // Locked owner keeps the grant even with TVALID low, so packets never interleave.
  always_comb begin
    w_gnt_vld = w_srch_vld;
    w_gnt_idx = w_srch_idx;
    if (r_state == ST_LOCKED) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = r_owner;
    end
  end

  assign w_acc      = w_adv & w_gnt_vld & S_AXIS_TVALID[w_gnt_idx] & ~RST;
  assign w_acc_last = w_acc & S_AXIS_TLAST[w_gnt_idx];

  // Next state: lock on a multi-beat first beat, unlock once TLAST is taken.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_last_grant_nxt = w_gnt_idx;
          if (!S_AXIS_TLAST[w_gnt_idx]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_gnt_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (w_acc_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM registers; pointer resets to the last port so port 0 wins first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_grant <= C_IDX_WIDTH'(C_NUM_PORTS - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  genvar g;
  generate
    for (g = 0; g < C_NUM_PORTS; g++) begin : g_port
      assign w_dat_arr[g]  = S_AXIS_TDATA[g*C_DATA_WIDTH +: C_DATA_WIDTH];
      assign w_strb_arr[g] = S_AXIS_TSTRB[g*C_STRB_WIDTH +: C_STRB_WIDTH];
      assign w_gnt_oh[g]   = w_gnt_vld & (w_gnt_idx == C_IDX_WIDTH'(g));
      assign S_AXIS_TREADY[g] = w_gnt_oh[g] & w_adv & ~RST;
      assign PKT_CNT[g*C_CNT_WIDTH +: C_CNT_WIDTH] = r_pkt_cnt[g];

      // Per-port packet counter, bumped on each accepted TLAST; wraps freely.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_pkt_cnt[g] <= '0;
        end else if (w_acc_last && (w_gnt_idx == C_IDX_WIDTH'(g))) begin
          r_pkt_cnt[g] <= r_pkt_cnt[g] + C_CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  // Output stage: load on acceptance, drop valid when drained with nothing new.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tstrb  <= '0;
    end else if (w_acc) begin
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= S_AXIS_TLAST[w_gnt_idx];
      r_m_tdata  <= w_dat_arr[w_gnt_idx];
      r_m_tstrb  <= w_strb_arr[w_gnt_idx];
    end else if (w_adv) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Grant indicator: winner of the last accepted beat, cleared once idle with no new beat.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_grant <= '0;
    end else if (w_acc) begin
      r_grant <= w_gnt_oh;
    end else if (r_state == ST_IDLE) begin
      r_grant <= '0;
    end
  end

  assign M_AXIS_TVALID = r_m_tvalid;
  assign M_AXIS_TLAST  = r_m_tlast;
  assign M_AXIS_TDATA  = r_m_tdata;
  assign M_AXIS_TSTRB  = r_m_tstrb;
  assign GRANT_ONEHOT  = r_grant;

endmodule

// File: tb/tb_cmac_tx_rr_arbiter.sv
// Directed bench for cmac_tx_rr_arbiter: per-port beat tables feed the slaves,
// a monitor logs every accepted master beat, and checks compare against hand-built expectations.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_cmac_tx_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 512;
  localparam int SW = DW / 8;
  localparam int CW = 32;

  logic                 CLK;
  logic                 RST;
  logic [NP-1:0]        S_AXIS_TVALID;
  logic [NP-1:0]        S_AXIS_TREADY;
  logic [NP-1:0]        S_AXIS_TLAST;
  logic [NP*DW-1:0]     S_AXIS_TDATA;
  logic [NP*SW-1:0]     S_AXIS_TSTRB;
  logic                 M_AXIS_TVALID;
  logic                 M_AXIS_TREADY;
  logic                 M_AXIS_TLAST;
  logic [DW-1:0]        M_AXIS_TDATA;
  logic [SW-1:0]        M_AXIS_TSTRB;
  logic [NP-1:0]        GRANT_ONEHOT;
  logic [NP*CW-1:0]     PKT_CNT;

  cmac_tx_rr_arbiter #(.C_NUM_PORTS(NP), .C_DATA_WIDTH(DW), .C_CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .GRANT_ONEHOT(GRANT_ONEHOT), .PKT_CNT(PKT_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Source beat tables
  logic [63:0] src_dat  [NP][16];
  logic [63:0] src_strb [NP][16];
  logic        src_last [NP][16];
  int          src_n    [NP];
  int          src_rd   [NP];
  logic        src_en   [NP];

  // Master-side log
  logic [63:0] mon_dat  [256];
  logic [63:0] mon_hi   [256];
  logic [63:0] mon_strb [256];
  logic        mon_last [256];
  logic [3:0]  mon_gnt  [256];
  int          mon_cyc  [256];
  int          mon_n = 0;

  logic        bp_mode = 1'b0;
  logic [3:0]  bp_pat  = 4'b1001;
  logic        watch3  = 1'b0;
  int          rdy3_viol = 0;
  int          hold_viol = 0;
  int          bp_stalls = 0;

  function automatic logic [63:0] mkdat(input int p, input int tag, input int b);
    return 64'hC0DE_0000_0000_0000 | (64'(p) << 16) | (64'(tag) << 8) | 64'(b);
  endfunction

  task automatic add_beat(input int p, input logic [63:0] d, input logic [63:0] s, input logic l);
    src_dat[p][src_n[p]]  = d;
    src_strb[p][src_n[p]] = s;
    src_last[p][src_n[p]] = l;
    src_n[p]++;
  endtask

  task automatic add_pkt(input int p, input int nb, input int tag);
    for (int b = 0; b < nb; b++) add_beat(p, mkdat(p, tag, b), '1, b == nb - 1);
  endtask

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      src_n[p] = 0; src_rd[p] = 0; src_en[p] = 1'b1;
    end
  endtask

  task automatic drive_srcs();
    for (int p = 0; p < NP; p++) begin
      int  i;
      logic v;
      i = (src_rd[p] < 16) ? src_rd[p] : 0;
      v = src_en[p] && (src_rd[p] < src_n[p]);
      S_AXIS_TVALID[p]            = v;
      S_AXIS_TLAST[p]             = v ? src_last[p][i] : 1'b0;
      S_AXIS_TDATA[p*DW +: DW]    = v ? {8{src_dat[p][i]}} : '0;
      S_AXIS_TSTRB[p*SW +: SW]    = v ? src_strb[p][i] : '0;
    end
    M_AXIS_TREADY = bp_mode ? bp_pat[cyc % 4] : 1'b1;
  endtask

  // Driver and monitor
  initial begin
    logic [NP-1:0] acc;
    logic          pv, pr;
    logic [63:0]   pd;
    pv = 1'b0; pr = 1'b0; pd = '0;
    clear_src();
    S_AXIS_TVALID = '0; S_AXIS_TLAST = '0; S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0;
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(negedge CLK);
      acc = S_AXIS_TVALID & S_AXIS_TREADY;
      if (M_AXIS_TVALID && M_AXIS_TREADY && mon_n < 256) begin
        mon_dat[mon_n]  = M_AXIS_TDATA[63:0];
        mon_hi[mon_n]   = M_AXIS_TDATA[DW-1 -: 64];
        mon_strb[mon_n] = M_AXIS_TSTRB;
        mon_last[mon_n] = M_AXIS_TLAST;
        mon_gnt[mon_n]  = GRANT_ONEHOT;
        mon_cyc[mon_n]  = cyc;
        mon_n++;
      end
      if (pv && !pr && (!M_AXIS_TVALID || M_AXIS_TDATA[63:0] !== pd)) hold_viol++;
      if (M_AXIS_TVALID && !M_AXIS_TREADY) bp_stalls++;
      pv = M_AXIS_TVALID; pr = M_AXIS_TREADY; pd = M_AXIS_TDATA[63:0];
      if (watch3 && S_AXIS_TREADY[3]) rdy3_viol++;
      @(posedge CLK);
      #1;
      for (int p = 0; p < NP; p++) if (acc[p]) src_rd[p]++;
      drive_srcs();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    #2;
  endtask

  task automatic wait_mon(input int target, input int budget);
    int k;
    k = 0;
    while (mon_n < target && k < budget) begin idle(1); k++; end
    if (mon_n < target) chk("wait_mon_timeout", 64'(mon_n), 64'(target));
  endtask

  task automatic wait_rd(input int p, input int target, input int budget);
    int k;
    k = 0;
    while (src_rd[p] < target && k < budget) begin idle(1); k++; end
    if (src_rd[p] < target) chk("wait_rd_timeout", 64'(src_rd[p]), 64'(target));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle(2);
    clear_src();
    idle(1);
    RST = 1'b0;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c, gaps, i3;
    RST = 1'b1;
    idle(3);
    // Reset state
    chk("rst_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_grant",  64'(GRANT_ONEHOT), 64'd0);
    chk("rst_sready", 64'(S_AXIS_TREADY), 64'd0);
    chk("rst_cnt0",   PKT_CNT[63:0], 64'd0);
    RST = 1'b0;
    idle(2);

    // Single port, 3-beat packet on port 2
    base = mon_n;
    c = cyc;
    add_beat(2, 64'hAAAA_AAAA_AAAA_AAAA, '1, 1'b0);
    add_beat(2, 64'hBBBB_BBBB_BBBB_BBBB, '1, 1'b0);
    add_beat(2, 64'hCCCC_CCCC_CCCC_CCCC, 64'h0000_0000_FFFF_FFFF, 1'b1);
    wait_mon(base + 3, 30);
    idle(2);
    chk("t1_d0", mon_dat[base],     64'hAAAA_AAAA_AAAA_AAAA);
    chk("t1_d1", mon_dat[base + 1], 64'hBBBB_BBBB_BBBB_BBBB);
    chk("t1_d2", mon_dat[base + 2], 64'hCCCC_CCCC_CCCC_CCCC);
    chk("t1_hi", mon_hi[base + 2],  64'hCCCC_CCCC_CCCC_CCCC);
    chk("t1_l",  {61'd0, mon_last[base], mon_last[base + 1], mon_last[base + 2]}, 64'd1);
    chk("t1_strb", mon_strb[base + 2], 64'h0000_0000_FFFF_FFFF);
    chk("t1_lat", 64'(mon_cyc[base]), 64'(c + 2));
    chk("t1_contig", 64'(mon_cyc[base + 2] - mon_cyc[base]), 64'd2);
    for (int i = 0; i < 3; i++) chk("t1_gnt", 64'(mon_gnt[base + i]), 64'b0100);
    chk("t1_cnt2", 64'(PKT_CNT[2*CW +: CW]), 64'd1);
    chk("t1_cnt0", 64'(PKT_CNT[0 +: CW]), 64'd0);

    // Round robin, all ports offering two 2-beat packets
    do_reset();
    base = mon_n;
    for (int p = 0; p < NP; p++) begin add_pkt(p, 2, 0); add_pkt(p, 2, 1); end
    wait_mon(base + 16, 60);
    idle(2);
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      chk("t2_dat",  mon_dat[base + i], mkdat((i / 2) % 4, i / 8, i % 2));
      chk("t2_last", 64'(mon_last[base + i]), 64'(i % 2));
      if (i > 0 && mon_cyc[base + i] != mon_cyc[base + i - 1] + 1) gaps++;
    end
    chk("t2_gaps", 64'(gaps), 64'd0);
    for (int p = 0; p < NP; p++) chk("t2_cnt", 64'(PKT_CNT[p*CW +: CW]), 64'd2);

    // Owner stall: port 1 locked, drops valid while port 3 waits
    clear_src();
    base = mon_n;
    add_pkt(1, 4, 5);
    wait_rd(1, 1, 30);
    src_en[1] = 1'b0;
    add_pkt(3, 2, 6);
    watch3 = 1'b1;
    idle(2);
    chk("t3_gnt_stall", 64'(GRANT_ONEHOT), 64'b0010);
    idle(3);
    watch3 = 1'b0;
    src_en[1] = 1'b1;
    wait_mon(base + 6, 40);
    idle(2);
    for (int i = 0; i < 4; i++) chk("t3_p1", mon_dat[base + i], mkdat(1, 5, i));
    chk("t3_p3b0", mon_dat[base + 4], mkdat(3, 6, 0));
    chk("t3_p3b1", mon_dat[base + 5], mkdat(3, 6, 1));
    chk("t3_stalled", 64'(mon_cyc[base + 2] - mon_cyc[base + 1] > 1), 64'd1);
    chk("t3_handover", 64'(mon_cyc[base + 4]), 64'(mon_cyc[base + 3] + 1));
    chk("t3_rdy3", 64'(rdy3_viol), 64'd0);

    // Single-beat packets alternating between ports 0 and 1
    clear_src();
    base = mon_n;
    for (int t = 0; t < 3; t++) begin add_pkt(0, 1, t); add_pkt(1, 1, t); end
    wait_mon(base + 6, 30);
    idle(2);
    gaps = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t5_dat", mon_dat[base + i], mkdat(i % 2, i / 2, 0));
      chk("t5_gnt", 64'(mon_gnt[base + i]), (i % 2 == 0) ? 64'b0001 : 64'b0010);
      if (i > 0 && mon_cyc[base + i] != mon_cyc[base + i - 1] + 1) gaps++;
    end
    chk("t5_gaps", 64'(gaps), 64'd0);

    // Backpressure: ready pattern 1,0,0,1 during a 6-beat packet
    clear_src();
    base = mon_n;
    hold_viol = 0;
    bp_stalls = 0;
    bp_mode = 1'b1;
    add_pkt(0, 6, 7);
    wait_mon(base + 6, 80);
    idle(4);
    bp_mode = 1'b0;
    idle(2);
    chk("t4_count", 64'(mon_n - base), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t4_dat",  mon_dat[base + i], mkdat(0, 7, i));
      chk("t4_last", 64'(mon_last[base + i]), 64'(i == 5));
    end
    chk("t4_hold", 64'(hold_viol), 64'd0);
    chk("t4_bp_seen", 64'(bp_stalls > 0), 64'd1);

    // Reset in the middle of a 4-beat packet
    clear_src();
    add_pkt(0, 4, 8);
    wait_rd(0, 2, 30);
    RST = 1'b1;
    #1;
    chk("t6_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("t6_mlast",  64'(M_AXIS_TLAST), 64'd0);
    chk("t6_mdata",  M_AXIS_TDATA[63:0], 64'd0);
    chk("t6_grant",  64'(GRANT_ONEHOT), 64'd0);
    chk("t6_sready", 64'(S_AXIS_TREADY), 64'd0);
    for (int p = 0; p < NP; p++) chk("t6_cnt", 64'(PKT_CNT[p*CW +: CW]), 64'd0);
    idle(2);
    clear_src();
    idle(1);
    RST = 1'b0;
    idle(1);
    base = mon_n;
    add_pkt(3, 1, 9);
    add_pkt(0, 1, 9);
    wait_mon(base + 2, 20);
    i3 = base + 1;
    chk("t6_first", mon_dat[base], mkdat(0, 9, 0));
    chk("t6_second", mon_dat[i3], mkdat(3, 9, 0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
